// File: rtl/mag_sq_pipe.sv
// mag_sq_pipe: squared magnitude |a|^2 of a signed complex fixed-point sample,
// plus a block-energy accumulator fed from the same pipeline.
//
// The magnitude pipeline has three stages. S1 registers the input, S2 forms
// the two full-width products, and S3 adds them, rounds, shifts and saturates
// into mag_out. A single stall condition (out_valid && !out_ready) freezes
// every stage and the accumulator. Bubbles move through the pipeline with
// valid=0 and are never squeezed out.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   a_real, a_imag       signed WIDTH-bit sample (Q format with FRAC fraction bits)
//   in_valid, in_last    sample valid; the sample closes the energy block early
//   in_ready             sample accepted this cycle when in_valid is high
//   mag_out              |a|^2 in the input Q format
//   out_valid, out_ready output handshake
//   eng_out, eng_valid   full-precision block energy, with a one-cycle strobe
//   sat_flag, sat_clr    sticky saturation flag; synchronous clear (clear wins)
module mag_sq_pipe #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int SAT_EN  = 1,
  parameter int RND_EN  = 0,
  parameter int ACC_LEN = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [WIDTH-1:0]                    a_real,
  input  logic [WIDTH-1:0]                    a_imag,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [WIDTH-1:0]                    mag_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2*WIDTH+$clog2(ACC_LEN):0]    eng_out,
  output logic                                eng_valid,
  output logic                                sat_flag,
  input  logic                                sat_clr
);

  localparam int PW = 2 * WIDTH;                 // product width
  localparam int SW = 2 * WIDTH + 1;             // sum width
  localparam int CW = $clog2(ACC_LEN);           // sample counter width
  localparam int EW = 2 * WIDTH + 1 + CW;        // energy width

  localparam logic [SW:0]      RND_ADD = (RND_EN != 32'sd0) ? ((SW+1)'(1) << (FRAC - 1)) : (SW+1)'(0);
  localparam logic [SW:0]      MAX_POS = (SW+1)'((2 ** (WIDTH - 1)) - 1);
  localparam logic [WIDTH-1:0] MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(ACC_LEN - 1);

  // Round at the FRAC boundary (when enabled) and drop the fraction bits.
  // One spare bit keeps the rounding addition from overflowing.
  function automatic logic [SW:0] scale_sum(input logic [SW-1:0] sum);
    logic [SW:0] t;
    t = {1'b0, sum} + RND_ADD;
    return t >> FRAC;
  endfunction

  logic                     stall_s;
  logic                     load_s;
  logic                     s1_valid_r, s1_last_r;
  logic signed [WIDTH-1:0]  s1_re_r, s1_im_r;
  logic                     s2_valid_r, s2_last_r;
  logic [PW-1:0]            s2_pre_r, s2_pim_r;
  logic [SW-1:0]            sum_s;
  logic [SW:0]              res_s;
  logic                     sat_hit_s;
  logic [WIDTH-1:0]         mag_next_s;
  logic [EW-1:0]            acc_r;
  logic [EW-1:0]            acc_sum_s;
  logic [CW-1:0]            cnt_r;
  logic                     blk_end_s;

  assign stall_s  = out_valid && !out_ready;
  assign in_ready = !stall_s;
  // S3 loads a real sample only when the pipeline advances and S2 holds one.
  assign load_s   = !stall_s && s2_valid_r;

  // Both products are squares and therefore non-negative, so the sum is unsigned.
  assign sum_s     = {1'b0, s2_pre_r} + {1'b0, s2_pim_r};
  assign res_s     = scale_sum(sum_s);
  assign acc_sum_s = acc_r + EW'(sum_s);
  assign blk_end_s = (cnt_r == CNT_LAST) || s2_last_r;

  // Saturate or wrap the scaled result into the output width.
  always_comb begin
    sat_hit_s  = 1'b0;
    mag_next_s = res_s[WIDTH-1:0];
    if ((SAT_EN != 32'sd0) && (res_s > MAX_POS)) begin
      sat_hit_s  = 1'b1;
      mag_next_s = MAG_MAX;
    end else begin
      sat_hit_s  = 1'b0;
      mag_next_s = res_s[WIDTH-1:0];
    end
  end

  // S1: input register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_re_r    <= '0;
      s1_im_r    <= '0;
    end else if (!stall_s) begin
      s1_valid_r <= in_valid;
      s1_last_r  <= in_last;
      s1_re_r    <= a_real;
      s1_im_r    <= a_imag;
    end
  end

  // S2: full-width signed squares; -2^(WIDTH-1) squared still fits in PW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_pre_r   <= '0;
      s2_pim_r   <= '0;
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_last_r;
      s2_pre_r   <= PW'(s1_re_r) * PW'(s1_re_r);
      s2_pim_r   <= PW'(s1_im_r) * PW'(s1_im_r);
    end
  end

  // S3: output register; mag_out keeps its last value across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      mag_out   <= '0;
    end else if (!stall_s) begin
      out_valid <= s2_valid_r;
      if (s2_valid_r) begin
        mag_out <= mag_next_s;
      end
    end
  end

  // Sticky saturation flag; a clear in the same cycle as a set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end else if (load_s && sat_hit_s) begin
      sat_flag <= 1'b1;
    end
  end

  // Block energy: accumulates unrounded sums, closes on count or in_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r     <= '0;
      cnt_r     <= '0;
      eng_out   <= '0;
      eng_valid <= 1'b0;
    end else begin
      eng_valid <= 1'b0;
      if (load_s) begin
        if (blk_end_s) begin
          eng_out   <= acc_sum_s;
          eng_valid <= 1'b1;
          acc_r     <= '0;
          cnt_r     <= '0;
        end else begin
          acc_r <= acc_sum_s;
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mag_sq_pipe.sv
// Bench for mag_sq_pipe. Two instances share the same stimulus:
//   dut_a: SAT_EN=1, RND_EN=0, ACC_LEN=4
//   dut_b: SAT_EN=0, RND_EN=1, ACC_LEN=4
// Expected magnitudes are queued when a sample is accepted and popped when an
// output is handed over. Block energies come from an integer reference model.
module tb_mag_sq_pipe;

  localparam int W  = 16;
  localparam int EW = 35;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  a_real = '0, a_imag = '0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, sat_clr = 1'b0;
  logic          in_ready_a, out_valid_a, eng_valid_a, sat_a;
  logic          in_ready_b, out_valid_b, eng_valid_b, sat_b;
  logic [W-1:0]  mag_a, mag_b;
  logic [EW-1:0] eng_a, eng_b;

  mag_sq_pipe #(.WIDTH(16), .FRAC(8), .SAT_EN(1), .RND_EN(0), .ACC_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .a_real(a_real), .a_imag(a_imag),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_a),
    .mag_out(mag_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .eng_out(eng_a), .eng_valid(eng_valid_a), .sat_flag(sat_a), .sat_clr(sat_clr));

  mag_sq_pipe #(.WIDTH(16), .FRAC(8), .SAT_EN(0), .RND_EN(1), .ACC_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .a_real(a_real), .a_imag(a_imag),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
    .mag_out(mag_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .eng_out(eng_b), .eng_valid(eng_valid_b), .sat_flag(sat_b), .sat_clr(sat_clr));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         last;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } vec_t;

  typedef struct {
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } exp_t;

  vec_t            tbl[13];
  exp_t            mq[$];
  longint unsigned eq[$];
  exp_t            pop_e;
  longint unsigned pop_eng;
  logic [W-1:0]    cur_ea, cur_eb;
  longint          sr, si;
  longint unsigned m_acc = 0;
  int              m_cnt = 0;
  int              n_vec = 0, n_miss = 0;
  int              eng_pulses = 0;
  longint unsigned last_eng = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop outputs, check energies, push accepted samples.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_a && out_ready) begin
        if (mq.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_out: got %0h expected no output", mag_a);
        end else begin
          pop_e = mq.pop_front();
          check("mag_a", mag_a, pop_e.ea);
          check("mag_b", mag_b, pop_e.eb);
          check("out_valid_b", out_valid_b, 1);
        end
      end
      if (eng_valid_a) begin
        eng_pulses++;
        last_eng = eng_a;
        if (eq.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL unexpected_eng: got %0h expected no pulse", eng_a);
        end else begin
          pop_eng = eq.pop_front();
          check("eng_a", eng_a, pop_eng);
          check("eng_b", eng_b, pop_eng);
          check("eng_valid_b", eng_valid_b, 1);
        end
      end
      if (in_valid && in_ready_a) begin
        mq.push_back('{cur_ea, cur_eb});
        sr = longint'($signed(a_real));
        si = longint'($signed(a_imag));
        m_acc += longint'(sr * sr + si * si);
        m_cnt++;
        if (m_cnt == 4 || in_last) begin
          eq.push_back(m_acc);
          m_acc = 0;
          m_cnt = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im, input logic last,
                      input logic [W-1:0] ea, input logic [W-1:0] eb);
    bit acc;
    int n;
    a_real = re; a_imag = im; in_last = last; in_valid = 1'b1;
    cur_ea = ea; cur_eb = eb;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = in_ready_a;
      step();
      n++;
    end
    if (!acc) begin
      n_vec++; n_miss++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain_empty", mq.size(), 0);
    step();
    step();
  endtask

  int           p0;
  logic [W-1:0] held;

  initial begin
    tbl[0]  = '{16'h0100, 16'h0000, 1'b0, 16'd256,   16'd256};
    tbl[1]  = '{16'h0000, 16'h0100, 1'b0, 16'd256,   16'd256};
    tbl[2]  = '{16'd12,   16'h0000, 1'b0, 16'd0,     16'd1};
    tbl[3]  = '{16'h8000, 16'h0000, 1'b0, 16'h7FFF,  16'h0000};
    tbl[4]  = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF,  16'hFE00};
    tbl[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'd0,     16'd0};
    tbl[6]  = '{16'd1000, 16'hF830, 1'b0, 16'd19531, 16'd19531};
    tbl[7]  = '{16'hFED4, 16'd400,  1'b0, 16'd976,   16'd977};
    tbl[8]  = '{16'd2896, 16'd2896, 1'b0, 16'h7FFF,  16'hFFF2};
    tbl[9]  = '{16'd181,  16'd181,  1'b0, 16'd255,   16'd256};
    tbl[10] = '{16'd16,   16'd8,    1'b0, 16'd1,     16'd1};
    tbl[11] = '{16'd128,  16'h0000, 1'b0, 16'd64,    16'd64};
    tbl[12] = '{16'd2048, 16'd2048, 1'b0, 16'h7FFF,  16'h8000};

    // Reset state, taken asynchronously before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_mag", mag_a, 0);
    check("rst_eng_valid", eng_valid_a, 0);
    check("rst_eng_out", eng_a, 0);
    check("rst_sat", sat_a, 0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready_a, 1);
    step();

    // Four samples close a block by count.
    p0 = eng_pulses;
    for (int i = 0; i < 4; i++) send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    idle();
    drain();
    check("blk4_pulses", eng_pulses - p0, 1);
    check("blk4_energy", last_eng, 64'd262144);

    // Three samples, in_last on the third, close a block early.
    p0 = eng_pulses;
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    send(16'd256, 16'd0, 1'b1, 16'd256, 16'd256);
    idle();
    drain();
    check("blk3_pulses", eng_pulses - p0, 1);
    check("blk3_energy", last_eng, 64'd196608);

    // Latency: output visible three cycles after the acceptance cycle.
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    idle();
    check("lat_c1", out_valid_a, 0);
    step();
    check("lat_c2", out_valid_a, 0);
    step();
    check("lat_c3_valid", out_valid_a, 1);
    check("lat_c3_mag", mag_a, 16'd256);
    drain();

    // in_last on the sample that also reaches ACC_LEN gives one pulse.
    p0 = eng_pulses;
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    send(16'd256, 16'd0, 1'b1, 16'd256, 16'd256);
    idle();
    drain();
    check("coinc_pulses", eng_pulses - p0, 1);
    check("coinc_energy", last_eng, 64'd262144);

    // sat_clr in the same cycle as a saturating load wins.
    send(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 16'hFE00);
    idle();
    step();
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("satclr_valid", out_valid_a, 1);
    check("satclr_prio", sat_a, 0);
    send(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 16'hFE00);
    idle();
    step();
    step();
    check("sat_set_a", sat_a, 1);
    check("sat_never_b", sat_b, 0);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_cleared", sat_a, 0);
    drain();

    // Table vectors, streamed back to back.
    for (int i = 0; i < 13; i++) send(tbl[i].re, tbl[i].im, tbl[i].last, tbl[i].ea, tbl[i].eb);
    idle();
    drain();
    check("tbl_sat_a", sat_a, 1);
    check("tbl_sat_b", sat_b, 0);

    // Continuous stream with out_ready low for five cycles.
    fork
      begin
        for (int i = 0; i < 12; i++) send(tbl[i].re, tbl[i].im, tbl[i].last, tbl[i].ea, tbl[i].eb);
        idle();
      end
      begin
        repeat (6) step();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready_a, 0);
          check("stall_out_valid", out_valid_a, 1);
          if (j == 0) held = mag_a;
          else check("stall_hold", mag_a, held);
        end
        step();
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two samples in flight and a partly filled block.
    send(16'd256, 16'd0, 1'b1, 16'd256, 16'd256);
    idle();
    drain();
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    idle();
    drain();
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    send(16'd0, 16'd512, 1'b0, 16'd1024, 16'd1024);
    idle();
    rst_n = 1'b0;
    mq.delete();
    eq.delete();
    m_acc = 0;
    m_cnt = 0;
    p0 = eng_pulses;
    #1;
    check("midrst_out_valid", out_valid_a, 0);
    check("midrst_eng_valid", eng_valid_a, 0);
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready_a, 1);
    repeat (6) step();
    check("midrst_no_out", out_valid_a, 0);
    check("midrst_no_eng", eng_pulses - p0, 0);
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    send(16'd256, 16'd0, 1'b0, 16'd256, 16'd256);
    send(16'd0, 16'd512, 1'b0, 16'd1024, 16'd1024);
    send(16'd16, 16'd8, 1'b0, 16'd1, 16'd1);
    idle();
    drain();
    check("postrst_pulses", eng_pulses - p0, 1);
    check("postrst_energy", last_eng, 64'd393536);
    check("eng_queue_empty", eq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
